// File: rtl/cpu_defs.sv
// Shared definitions for the memory arbiter: requester IDs, FSM state encoding
// and request-length constants.
package cpu_defs;

  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_IF   = 2'd1;
  localparam logic [1:0] PORT_LS   = 2'd2;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  function automatic logic [2:0] clamp_len(input logic [2:0] len, input int max_len);
    clamp_len = (int'(len) > max_len) ? 3'(max_len) : len;
  endfunction

endpackage

// File: rtl/mem_arb_shifter.sv
// Byte-lane helper: inserts a RAM byte into the read assembly word and selects
// the outgoing byte of the store word, both indexed by the byte counter.
module mem_arb_shifter (
  input  logic [31:0] asm_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  ins_lane_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  sel_lane_i,
  output logic [31:0] asm_o,
  output logic [7:0]  byte_o
);

  logic [7:0] lanes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign asm_o[8*gi +: 8] = (ins_lane_i == 2'(gi)) ? byte_i : asm_i[8*gi +: 8];
      assign lanes[gi]        = wdata_i[8*gi +: 8];
    end
  endgenerate

  assign byte_o = lanes[sel_lane_i];

endmodule

// File: rtl/mem_arbiter.sv
// Byte-wide RAM arbiter between instruction fetch and load/store; serialises
// 1/2/4-byte requests. Define MEM_ARB_RR_EN for round-robin instead of fixed LS priority.
module mem_arbiter
  import cpu_defs::*;
#(
  parameter int RD_LAT  = 1,
  parameter int MAX_LEN = int'(LEN_W)
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_re,
  input  logic [31:0] if_addr,
  input  logic [2:0]  if_len,
  output logic        if_busy,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_re,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_busy,
  output logic        ls_done,
  output logic [31:0] ls_data,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din
);

  localparam logic [7:0] RD_LAT_C = 8'(RD_LAT);

  arb_state_e  state_q;
  logic [1:0]  owner_q;
  logic [31:0] addr_q;
  logic [2:0]  len_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt_q;
  logic [31:0] asm_q;
  logic [31:0] ram_a_q;
  logic        ram_wr_q;
  logic [7:0]  ram_dout_q;
  logic        if_busy_q, ls_busy_q;
  logic        if_done_q, ls_done_q;
  logic [31:0] if_data_q, ls_data_q;
  logic        hold_if_q, hold_ls_q;
`ifdef MEM_ARB_RR_EN
  logic        last_ls_q;
`endif

  logic        req_if, req_ls, pick_if, pick_ls, g_we;
  logic [31:0] g_addr;
  logic [2:0]  g_len;
  logic [7:0]  cnt_inc, cap_idx, len_w;
  logic [31:0] asm_ins;
  logic [7:0]  wr_byte;

  // A port whose done pulsed last cycle is masked so its stale level request is not re-served.
  always_comb begin
    req_if  = if_re & ~hold_if_q;
    req_ls  = (ls_re | ls_we) & ~hold_ls_q;
`ifdef MEM_ARB_RR_EN
    pick_ls = req_ls & (~req_if | ~last_ls_q);
`else
    pick_ls = req_ls;
`endif
    pick_if = req_if & ~pick_ls;
    g_we    = pick_ls & ls_we;
    g_addr  = pick_ls ? ls_addr : if_addr;
    g_len   = clamp_len(pick_ls ? ls_len : if_len, MAX_LEN);
  end

  assign cnt_inc = cnt_q + 8'd1;
  assign cap_idx = cnt_q - RD_LAT_C;
  assign len_w   = {5'd0, len_q};

  mem_arb_shifter u_shifter (
    .asm_i      (asm_q),
    .byte_i     (ram_din),
    .ins_lane_i (cap_idx[1:0]),
    .wdata_i    (wdata_q),
    .sel_lane_i (cnt_inc[1:0]),
    .asm_o      (asm_ins),
    .byte_o     (wr_byte)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      owner_q    <= PORT_NONE;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      ram_a_q    <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
      if_busy_q  <= 1'b0;
      ls_busy_q  <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_data_q  <= '0;
      hold_if_q  <= 1'b0;
      hold_ls_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_ls_q  <= 1'b0;
`endif
    end else if (rdy_in) begin
      hold_if_q <= if_done_q;
      hold_ls_q <= ls_done_q;
      case (state_q)
        ST_IDLE: begin
          if (pick_if || pick_ls) begin
            owner_q   <= pick_ls ? PORT_LS : PORT_IF;
            addr_q    <= g_addr;
            len_q     <= g_len;
            wdata_q   <= ls_wdata;
            cnt_q     <= '0;
            asm_q     <= '0;
            if_busy_q <= pick_ls;
            ls_busy_q <= pick_if;
`ifdef MEM_ARB_RR_EN
            last_ls_q <= pick_ls;
`endif
            if (g_len == 3'd0) begin
              state_q <= ST_DONE;
              if (pick_ls) begin
                ls_done_q <= 1'b1;
                if (!g_we) ls_data_q <= '0;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= '0;
              end
            end else if (g_we) begin
              state_q    <= ST_WR;
              ram_wr_q   <= 1'b1;
              ram_a_q    <= g_addr;
              ram_dout_q <= ls_wdata[7:0];
            end else begin
              state_q <= ST_RD;
              ram_a_q <= g_addr;
            end
          end
        end

        // Address k is issued in RD cycle k; its byte is captured RD_LAT cycles later.
        ST_RD: begin
          cnt_q   <= cnt_inc;
          ram_a_q <= (cnt_inc < len_w) ? addr_q + {24'd0, cnt_inc} : 32'd0;
          if (cnt_q >= RD_LAT_C) begin
            asm_q <= asm_ins;
            if (cap_idx == len_w - 8'd1) begin
              state_q <= ST_DONE;
              if (owner_q == PORT_LS) begin
                ls_done_q <= 1'b1;
                ls_data_q <= asm_ins;
              end else begin
                if_done_q <= 1'b1;
                if_data_q <= asm_ins;
              end
            end
          end
        end

        ST_WR: begin
          if (cnt_inc < len_w) begin
            cnt_q      <= cnt_inc;
            ram_a_q    <= addr_q + {24'd0, cnt_inc};
            ram_dout_q <= wr_byte;
          end else begin
            state_q    <= ST_DONE;
            ram_wr_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ls_done_q  <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q   <= ST_IDLE;
          owner_q   <= PORT_NONE;
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
          if_busy_q <= 1'b0;
          ls_busy_q <= 1'b0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_a    = ram_a_q;
  assign ram_wr   = ram_wr_q & rdy_in;
  assign ram_dout = ram_dout_q;
  assign if_busy  = if_busy_q;
  assign ls_busy  = ls_busy_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = if_data_q;
  assign ls_data  = ls_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide RAM model of
// one-cycle read latency that shares the system enable rdy_in.
module tb_mem_arbiter;
  import cpu_defs::*;

  localparam int NT = 24;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_re, ls_re, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata;
  logic [2:0]  if_len, ls_len;
  logic        if_busy, if_done, ls_busy, ls_done;
  logic [31:0] if_data, ls_data, ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] t_ra [NT];
  logic [7:0]  t_do [NT];
  logic        t_wr [NT];
  logic        t_ib [NT];
  logic        t_lb [NT];
  logic        t_id [NT];
  logic        t_ld [NT];

  bit [7:0] mem [1024];
  bit       wv  [1024];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .if_re    (if_re),
    .if_addr  (if_addr),
    .if_len   (if_len),
    .if_busy  (if_busy),
    .if_done  (if_done),
    .if_data  (if_data),
    .ls_re    (ls_re),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_len   (ls_len),
    .ls_wdata (ls_wdata),
    .ls_busy  (ls_busy),
    .ls_done  (ls_done),
    .ls_data  (ls_data),
    .ram_a    (ram_a),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din)
  );

  // Initial RAM image: fetch word 0x00000513 at 0x100, elsewhere addr[7:0]^0x5A.
  function automatic logic [7:0] init_byte(input logic [9:0] a);
    case (a)
      10'h100: init_byte = 8'h13;
      10'h101: init_byte = 8'h05;
      10'h102, 10'h103: init_byte = 8'h00;
      default: init_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rdy_in) begin
      ram_din <= wv[ram_a[9:0]] ? mem[ram_a[9:0]] : init_byte(ram_a[9:0]);
      if (ram_wr) begin
        mem[ram_a[9:0]] <= ram_dout;
        wv[ram_a[9:0]]  <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int first_hi(input bit ls);
    for (int n = 0; n < NT; n++)
      if (ls ? t_ld[n] : t_id[n]) return n;
    return -1;
  endfunction

  function automatic int n_hi(input bit ls);
    int c = 0;
    for (int n = 0; n < NT; n++)
      if (ls ? t_ld[n] : t_id[n]) c++;
    return c;
  endfunction

  // Samples outputs each cycle (index 0 = cycle the request is first driven), drops a
  // request lag cycles after its done, and optionally freezes rdy_in for 3 cycles.
  task automatic trace(input int ncyc, input int lag, input int frz_at);
    int drop_if = -1;
    int drop_ls = -1;
    for (int n = 0; n < NT; n++) begin
      t_ra[n] = '0; t_do[n] = '0; t_wr[n] = 1'b0;
      t_ib[n] = 1'b0; t_lb[n] = 1'b0; t_id[n] = 1'b0; t_ld[n] = 1'b0;
    end
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      t_ra[n] = ram_a; t_do[n] = ram_dout; t_wr[n] = ram_wr;
      t_ib[n] = if_busy; t_lb[n] = ls_busy; t_id[n] = if_done; t_ld[n] = ls_done;
      if (if_done && drop_if < 0) drop_if = n + lag;
      if (ls_done && drop_ls < 0) drop_ls = n + lag;
      @(posedge clk);
      #1;
      if (drop_if >= 0 && n + 1 >= drop_if) if_re = 1'b0;
      if (drop_ls >= 0 && n + 1 >= drop_ls) begin
        ls_re = 1'b0;
        ls_we = 1'b0;
      end
      if (n + 1 == frz_at) rdy_in = 1'b0;
      if (n + 1 == frz_at + 3) rdy_in = 1'b1;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [2:0] l);
    @(posedge clk);
    #1;
    if_re = 1'b1; if_addr = a; if_len = l;
  endtask

  task automatic lsreq(input logic we, input logic [31:0] a, input logic [2:0] l,
                       input logic [31:0] wd);
    @(posedge clk);
    #1;
    ls_re = ~we; ls_we = we; ls_addr = a; ls_len = l; ls_wdata = wd;
  endtask

  initial begin
    int wcount;
    rst_in = 1'b1; rdy_in = 1'b1;
    if_re = 1'b0; if_addr = '0; if_len = '0;
    ls_re = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_flags", {18'd0, ram_wr, ram_dout, if_busy, ls_busy, if_done, ls_done}, 32'h0);
    check("rst_if_data", if_data, 32'h0);
    check("rst_ls_data", ls_data, 32'h0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;

    // T1: 4-byte fetch at 0x100, request held one cycle past done (holdoff)
    fetch(32'h100, LEN_W);
    trace(12, 2, -1);
    $display("txn fetch4 @100: done@%0d data=%h", first_hi(0), if_data);
    check("t1_latency", first_hi(0), 6);
    check("t1_pulses", n_hi(0), 1);
    check("t1_data", if_data, 32'h0000_0513);
    check("t1_ra1", t_ra[1], 32'h100);
    check("t1_ra4", t_ra[4], 32'h103);
    check("t1_ls_busy1", t_lb[1], 1);
    check("t1_ls_busy6", t_lb[6], 1);
    check("t1_ls_busy7", t_lb[7], 0);
    check("t1_if_busy", t_ib[3], 0);
    check("t1_holdoff_ra", t_ra[8], 32'h0);

    // T2: 2-byte store 0xABCD at 0x200
    lsreq(1'b1, 32'h200, LEN_H, 32'h0000_ABCD);
    trace(8, 1, -1);
    wcount = 0;
    for (int n = 0; n < NT; n++) if (t_wr[n]) wcount++;
    $display("txn store2 @200: done@%0d writes=%0d", first_hi(1), wcount);
    check("t2_latency", first_hi(1), 3);
    check("t2_wr_count", wcount, 2);
    check("t2_b0_a", t_ra[1], 32'h200);
    check("t2_b0_d", t_do[1], 8'hCD);
    check("t2_b1_a", t_ra[2], 32'h201);
    check("t2_b1_d", t_do[2], 8'hAB);
    check("t2_wr_done", t_wr[3], 0);
    check("t2_if_busy1", t_ib[1], 1);
    check("t2_if_busy3", t_ib[3], 1);

    // T2b: load the stored halfword back, zero-extended
    lsreq(1'b0, 32'h200, LEN_H, 32'h0);
    trace(8, 1, -1);
    $display("txn load2 @200: done@%0d data=%h", first_hi(1), ls_data);
    check("t2b_latency", first_hi(1), 4);
    check("t2b_data", ls_data, 32'h0000_ABCD);

    // T3: simultaneous load (4 @0x100) and fetch (2 @0x3FE)
    @(posedge clk);
    #1;
    ls_re = 1'b1; ls_addr = 32'h100; ls_len = LEN_W;
    if_re = 1'b1; if_addr = 32'h3FE; if_len = LEN_H;
    trace(16, 1, -1);
    $display("txn collide: ls_done@%0d if_done@%0d ls=%h if=%h",
             first_hi(1), first_hi(0), ls_data, if_data);
`ifdef MEM_ARB_RR_EN
    check("t3_if_first", first_hi(0), 4);
    check("t3_ls_second", first_hi(1), 11);
    check("t3_ls_busy", t_lb[2], 1);
`else
    check("t3_ls_first", first_hi(1), 6);
    check("t3_if_second", first_hi(0), 11);
    check("t3_if_busy", t_ib[3], 1);
    check("t3_ls_busy", t_lb[9], 1);
`endif
    check("t3_ls_data", ls_data, 32'h0000_0513);
    check("t3_if_data", if_data, 32'h0000_A5A4);

    // T4: rdy_in low for 3 cycles mid-read
    fetch(32'h100, LEN_W);
    trace(14, 1, 3);
    $display("txn fetch4 frozen: done@%0d data=%h", first_hi(0), if_data);
    check("t4_latency", first_hi(0), 9);
    check("t4_ra_frz3", t_ra[3], 32'h102);
    check("t4_ra_frz5", t_ra[5], 32'h102);
    check("t4_ra_res6", t_ra[6], 32'h102);
    check("t4_ra_res7", t_ra[7], 32'h103);
    check("t4_data", if_data, 32'h0000_0513);

    // T5: address wrap-around
    fetch(32'hFFFF_FFFE, LEN_W);
    trace(10, 1, -1);
    $display("txn fetch4 @FFFFFFFE: done@%0d data=%h", first_hi(0), if_data);
    check("t5_ra1", t_ra[1], 32'hFFFF_FFFE);
    check("t5_ra2", t_ra[2], 32'hFFFF_FFFF);
    check("t5_ra3", t_ra[3], 32'h0000_0000);
    check("t5_ra4", t_ra[4], 32'h0000_0001);
    check("t5_data", if_data, 32'h5B5A_A5A4);

    // T7: zero-length load and over-long fetch
    lsreq(1'b0, 32'h100, 3'd0, 32'h0);
    trace(6, 1, -1);
    $display("txn load0: done@%0d data=%h", first_hi(1), ls_data);
    check("t7_len0_latency", first_hi(1), 1);
    check("t7_len0_data", ls_data, 32'h0);
    check("t7_len0_owner_busy", t_lb[1], 0);
    check("t7_len0_loser_busy", t_ib[1], 1);
    fetch(32'h100, 3'd7);
    trace(10, 1, -1);
    $display("txn fetch7 clamped: done@%0d data=%h", first_hi(0), if_data);
    check("t7_clamp_latency", first_hi(0), 6);
    check("t7_clamp_ra5", t_ra[5], 32'h0);
    check("t7_clamp_data", if_data, 32'h0000_0513);

    // T6: reset during byte 1 of a 4-byte store, then a normal fetch
    lsreq(1'b1, 32'h300, LEN_W, 32'h1122_3344);
    @(negedge clk);
    @(negedge clk);
    check("t6_b0_a", ram_a, 32'h300);
    check("t6_b0_d", ram_dout, 8'h44);
    @(posedge clk);
    #2;
    check("t6_b1_a", ram_a, 32'h301);
    check("t6_b1_flags", {ram_wr, if_busy}, 2'b11);
    rst_in = 1'b1;
    #1;
    check("t6_rst_a", ram_a, 32'h0);
    check("t6_rst_flags", {18'd0, ram_wr, ram_dout, if_busy, ls_busy, if_done, ls_done}, 32'h0);
    check("t6_rst_data", if_data, 32'h0);
    ls_we = 1'b0;
    @(negedge clk);
    rst_in = 1'b0;
    $display("txn store4 @300 reset mid-write");
    fetch(32'h100, LEN_B);
    trace(8, 1, -1);
    $display("txn fetch1 @100 after reset: done@%0d data=%h", first_hi(0), if_data);
    check("t6_after_latency", first_hi(0), 3);
    check("t6_after_data", if_data, 32'h0000_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
